// File: rtl/ser_frame_rx.sv
// Serial frame receiver: sliding-window sync hunt, MSB-first payload capture, one-deep valid/ready output.
// Optional even-parity bit after the payload is enabled by defining SER_FRAME_RX_PARITY_EN.
module ser_frame_rx #(
  parameter int                SYNC_W       = 6,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 6'b011010,
  parameter int                PAYLOAD_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 serdata_i,
  input  logic                 sample_en_i,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] frame_o,
  output logic                 valid_o,
  output logic                 sync_det_o,
  output logic                 overrun_o,
  output logic                 parity_err_o,
  output logic                 busy_o
);

  localparam int BC_W = $clog2(PAYLOAD_W + 1);
  localparam int FC_W = $clog2(SYNC_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(PAYLOAD_W - 1);
  localparam logic [FC_W-1:0] FILL_FULL = FC_W'(SYNC_W);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
`ifdef SER_FRAME_RX_PARITY_EN
    PARITY  = 2'd2,
`endif
    PAYLOAD = 2'd1
  } state_t;

`ifdef SER_FRAME_RX_PARITY_EN
  function automatic logic even_parity_ok(input logic [PAYLOAD_W-1:0] data, input logic pbit);
    return ~(^{data, pbit});
  endfunction
`endif

  state_t                state_r, state_n;
  logic [SYNC_W-1:0]     sr_r, sr_n, sr_shift;
  logic [FC_W-1:0]       fill_r, fill_n, fill_sat;
  logic [BC_W-1:0]       bit_r, bit_n;
  logic [PAYLOAD_W-1:0]  pay_r, pay_n, pay_shift, done_data;
  logic [PAYLOAD_W-1:0]  frame_r, frame_n;
  logic                  valid_r, valid_n;
  logic                  sync_r, sync_n;
  logic                  ovr_r, ovr_n;
  logic                  busy_r, busy_n;
  logic                  perr_n;
  logic                  done;

  assign sr_shift  = {sr_r[SYNC_W-2:0], serdata_i};
  assign fill_sat  = (fill_r == FILL_FULL) ? fill_r : fill_r + FC_W'(1);
  assign pay_shift = (PAYLOAD_W)'({pay_r, serdata_i});

  // Next-state, datapath and output-handshake logic
  always_comb begin
    state_n   = state_r;
    sr_n      = sr_r;
    fill_n    = fill_r;
    bit_n     = bit_r;
    pay_n     = pay_r;
    frame_n   = frame_r;
    sync_n    = 1'b0;
    ovr_n     = 1'b0;
    perr_n    = 1'b0;
    done      = 1'b0;
    done_data = pay_shift;

    if (valid_r && ready_i) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end

    case (state_r)
      HUNT: begin
        if (sample_en_i) begin
          sr_n   = sr_shift;
          fill_n = fill_sat;
          if ((fill_sat == FILL_FULL) && (sr_shift == SYNC_PATTERN)) begin
            state_n = PAYLOAD;
            bit_n   = '0;
            fill_n  = '0;
            sync_n  = 1'b1;
          end else begin
            state_n = HUNT;
          end
        end else begin
          state_n = HUNT;
        end
      end
      PAYLOAD: begin
        if (sample_en_i) begin
          pay_n = pay_shift;
          if (bit_r == LAST_BIT) begin
            bit_n = '0;
`ifdef SER_FRAME_RX_PARITY_EN
            state_n = PARITY;
`else
            done = 1'b1;
`endif
          end else begin
            bit_n = bit_r + BC_W'(1);
          end
        end else begin
          state_n = PAYLOAD;
        end
      end
`ifdef SER_FRAME_RX_PARITY_EN
      PARITY: begin
        if (sample_en_i) begin
          done_data = pay_r;
          if (even_parity_ok(pay_r, serdata_i)) begin
            done = 1'b1;
          end else begin
            perr_n  = 1'b1;
            state_n = HUNT;
            sr_n    = '0;
            fill_n  = '0;
          end
        end else begin
          state_n = PARITY;
        end
      end
`endif
      default: begin
        state_n = HUNT;
        sr_n    = '0;
        fill_n  = '0;
        bit_n   = '0;
      end
    endcase

    // A completed frame loads if the output slot is free or being drained on this edge
    if (done) begin
      state_n = HUNT;
      sr_n    = '0;
      fill_n  = '0;
      if (!valid_r || ready_i) begin
        frame_n = done_data;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else begin
      frame_n = frame_n;
    end

    busy_n = (state_n != HUNT);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= HUNT;
      sr_r    <= '0;
      fill_r  <= '0;
      bit_r   <= '0;
      pay_r   <= '0;
      frame_r <= '0;
      valid_r <= 1'b0;
      sync_r  <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      sr_r    <= sr_n;
      fill_r  <= fill_n;
      bit_r   <= bit_n;
      pay_r   <= pay_n;
      frame_r <= frame_n;
      valid_r <= valid_n;
      sync_r  <= sync_n;
      ovr_r   <= ovr_n;
      busy_r  <= busy_n;
    end
  end

`ifdef SER_FRAME_RX_PARITY_EN
  logic perr_r;

  // Parity-error pulse register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= perr_n;
    end
  end

  assign parity_err_o = perr_r;
`else
  assign parity_err_o = 1'b0;
`endif

  assign frame_o    = frame_r;
  assign valid_o    = valid_r;
  assign sync_det_o = sync_r;
  assign overrun_o  = ovr_r;
  assign busy_o     = busy_r;

endmodule

// File: doc/ser_frame_rx.md
Name: ser_frame_rx

Overview:
Parametrised serial frame receiver; next generation of the fixed 6-bit sync detector.
- Hunts a configurable sync word on a 1-bit serial input using true sliding-window matching, so overlapping sync candidates are caught.
- After sync, shifts in a PAYLOAD_W-bit payload, MSB first.
- Presents the payload through a one-deep valid/ready output register with overrun reporting.
- Sits between the serial pin sampler and the packet consumer.

Parameters:
SYNC_W, 6, sync word length in bits (>=2)
SYNC_PATTERN, 6'b011010, sync word; MSB is the first bit received
PAYLOAD_W, 8, payload length in bits (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
serdata_i  in  1  serial data bit
sample_en_i  in  1  bit strobe; serdata_i consumed only on edges where this is 1
ready_i  in  1  consumer accepts frame_o
frame_o  out  PAYLOAD_W  received payload
valid_o  out  1  frame_o holds an unconsumed frame
sync_det_o  out  1  one-cycle pulse, sync word matched
overrun_o  out  1  one-cycle pulse, completed frame dropped
parity_err_o  out  1  one-cycle pulse, parity mismatch (see Optional Feature)
busy_o  out  1  receiver is past sync (state != HUNT)

Behaviour:
- Reset: state=HUNT, sync shift reg=0, fill count=0, bit count=0, frame_o=0. valid_o, sync_det_o, overrun_o, parity_err_o and busy_o are all 0.
- Nothing advances on edges with sample_en_i=0. The output handshake still runs on every edge.
- HUNT:
  - Each strobe: sr <= {sr[SYNC_W-2:0], serdata_i}; fill count saturates at SYNC_W.
  - Match: fill==SYNC_W (counting the current bit) and the shifted value == SYNC_PATTERN.
  - On match: sync_det_o=1 for the next cycle, go to PAYLOAD, bit count=0.
  - No match: stay in HUNT, keep the window. Matching is sliding, with no restart to the initial state on a mismatch.
- PAYLOAD: each strobe shifts serdata_i into the payload reg, MSB first, and increments the bit count.
- Strobe carrying the last bit (bit count==PAYLOAD_W-1): frame completes at that edge.
  - If valid_o==0, or valid_o&&ready_i on that same edge: frame_o<=payload, valid_o=1 from the next cycle. Latency is 1 clock after the last-bit edge.
  - Otherwise: frame dropped, frame_o unchanged, overrun_o pulses 1 cycle.
  - In both cases: return to HUNT with fill count=0 and sr=0. A fresh SYNC_W bits are required; payload bits never form a sync match.
- Handshake:
  - valid_o&&ready_i at an edge clears valid_o, unless a new frame loads on the same edge, in which case valid_o stays 1 with the new data.
  - frame_o stays stable while valid_o&&!ready_i.
  - ready_i while valid_o=0 is ignored.
- busy_o=1 in PAYLOAD (and PARITY).
- Reset mid-operation: immediate return to reset values. A partial frame and any held frame are discarded.
- Widths:
  - Bit count: $clog2(PAYLOAD_W+1) bits.
  - Fill count: $clog2(SYNC_W+1) bits.
  - No wrap-around; counters are cleared on state exit.

Optional Feature:
Macro SER_FRAME_RX_PARITY_EN.
- Defined:
  - After the last payload bit, a PARITY state consumes one extra strobed bit.
  - Even parity is required: XOR of payload and parity bit == 0.
  - Match: the frame-complete rules above apply at the parity edge.
  - Mismatch: frame discarded, parity_err_o pulses 1 cycle, return to HUNT, valid_o and frame_o untouched.
- Not defined: no PARITY state; frame completes on the last payload bit; parity_err_o tied 0.

Test Plan:
- Reset, sample_en_i=1 every cycle, ready_i=1, stream 011010 then 10100101 -> sync_det_o one pulse after 6th bit; valid_o high exactly 1 cycle with frame_o=8'hA5 after 14th bit; busy_o high for the 8 payload cycles.
- Overlapping sync: stream 011011010 then 00111100 -> single sync_det_o after 9th bit, frame_o=8'h3C; no false sync_det_o earlier.
- Backpressure: ready_i=0, frames A5 then 5A -> valid_o held, frame_o=8'hA5 throughout, overrun_o pulses once at the end of 5A. Then ready_i=1 for 1 cycle -> valid_o=0.
- Strobe gaps: sample_en_i every 3rd cycle, serdata_i toggling on non-strobe cycles, frame 011010+A5 -> frame_o=8'hA5, same pulse counts as test 1.
- Reset mid-payload: rst_i after 4 payload bits -> all outputs 0 and busy_o=0 immediately. Then 011010+8'hFF -> frame_o=8'hFF. Bits sent before the 6 new sync bits produce no sync_det_o.
- With SER_FRAME_RX_PARITY_EN:
  - 011010+A5+parity 0 -> valid_o, frame_o=8'hA5.
  - 011010+A5+parity 1 -> parity_err_o pulse, valid_o stays 0.
